if_fetch_queue: RTL and testbench

Parametrised instruction-fetch stage that replaces the fixed single-register fetch path.
- Drives a valid/ready request port to instruction memory, with in-order responses of variable latency.
- Holds up to MAX_OUTST requests in flight.
- Buffers returned instructions with their PC in a DEPTH-entry queue that feeds decode through a valid/ready handshake.
- A redirect (branch/jump) flushes the queue and silently drops any responses still in flight.

---
 rtl/if_fetch_queue_pkg.sv | 17 +
 rtl/if_fetch_queue_fifo.sv | 51 +++++
 rtl/if_fetch_queue.sv | 97 +++++++++
 tb/tb_if_fetch_queue.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// if_pkg: shared widths, PC increment rule and fetch-entry layout for the fetch stage
package if_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ILEN_DEF = 32;
    localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] instr;
    } fetch_entry_t;

    function automatic int pc_inc_of(input int ilen);
        return ilen / 8;
    endfunction

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of {pc, instr} words with flush
module fetch_fifo
    import if_pkg::*;
#(
    parameter int W = $bits(fetch_entry_t),
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [CW-1:0] count,
    output logic [W-1:0]  rdata
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && count != '0;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign rdata   = mem[rp];

    // Storage and pointers; entries are cleared on reset so the head reads zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp      <= wp + AW'(1);
            end
            if (do_pop) rp <= rp + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: credit-limited instruction fetch with in-flight drop on redirect
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ILEN = ILEN_DEF,
    parameter int DEPTH = 4,
    parameter int MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [ILEN-1:0] id_instr
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] PC_INC = XLEN'(pc_inc_of(ILEN));

    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      rsp_pc;
    logic [OW-1:0]        outst;
    logic [OW-1:0]        drop;
    logic [CW-1:0]        count;
    logic [CW:0]          inflight;
    logic [XLEN+ILEN-1:0] head;
    logic                 fire;
    logic                 rsp_ok;
    logic                 push;
    logic                 pop;

    // Every issued request reserves a queue slot, so a response always has room
    assign inflight       = {1'b0, count} + (CW+1)'(outst);
    assign imem_req_valid = reset && !redirect_valid && outst < OW'(MAX_OUTST)
                            && inflight < (CW+1)'(DEPTH);
    assign imem_req_addr  = pc;
    assign fire           = imem_req_valid && imem_req_ready;
    assign rsp_ok         = imem_rsp_valid && outst != '0;
    assign push           = rsp_ok && drop == '0 && !redirect_valid;
    assign id_valid       = count != '0;
    assign pop            = id_valid && id_ready;
    assign id_pc          = head[XLEN+ILEN-1:ILEN];
    assign id_instr       = head[ILEN-1:0];
    assign id_pc_plus4    = id_pc + PC_INC;

    fetch_fifo #(
        .W     (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({rsp_pc, imem_rsp_data}),
        .count (count),
        .rdata (head)
    );

    // PC, response PC, credit and drop tracking; a redirect turns everything in flight into drops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= RESET_PC;
            rsp_pc <= RESET_PC;
            outst  <= '0;
            drop   <= '0;
        end else if (redirect_valid) begin
            pc     <= redirect_pc;
            rsp_pc <= redirect_pc;
            outst  <= outst - OW'(rsp_ok);
            drop   <= outst - OW'(rsp_ok);
        end else begin
            if (fire) pc <= pc + PC_INC;
            outst <= outst + OW'(fire) - OW'(rsp_ok);
            if (rsp_ok && drop != '0) drop <= drop - OW'(1);
            if (push) rsp_pc <= rsp_pc + PC_INC;
        end
    end

    // A response with nothing in flight breaks the memory protocol; it is ignored above
    always_ff @(posedge clk) begin
        if (reset) assert (!(imem_rsp_valid && outst == '0))
            else $warning("imem response with no request outstanding");
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed table, corner sequences and random traffic against a stream model
module tb_if_fetch_queue;

    logic        clk = 0;
    logic        reset = 0;
    logic        redirect_valid = 0;
    logic [31:0] redirect_pc = 0;
    logic        imem_req_valid;
    logic        imem_req_ready = 0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 0;
    logic [31:0] imem_rsp_data = 0;
    logic        id_valid;
    logic        id_ready = 0;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;

    if_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_instr       (id_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } mreq_t;

    typedef struct {
        bit          idr;
        bit          men;
        bit          rv;
        logic [31:0] addr;
        bit          idv;
        logic [31:0] pc;
    } vec_t;

    mreq_t       memq[$];
    logic [31:0] dq[$];
    vec_t        tbl[11];
    int          ncmp = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          lat = 1;
    int          nfire = 0;
    bit          mem_en = 1;
    bit          stray = 0;
    logic [31:0] m_pc = 0;
    logic        s_rv;
    logic        s_idv;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_p4;
    logic [31:0] s_instr;

    function automatic logic [31:0] rsp_of(input logic [31:0] a);
        return a | 32'hA000_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: present memory response, compare against the stream model, advance the model
    task automatic tick();
        bit    rsp;
        bit    erv;
        bit    fire;
        bit    pop;
        mreq_t e;
        rsp = mem_en && memq.size() > 0 && memq[0].due <= cyc;
        imem_rsp_valid = rsp || stray;
        imem_rsp_data  = rsp ? rsp_of(memq[0].addr) : 32'h0;
        #1;
        s_rv = imem_req_valid; s_addr = imem_req_addr; s_idv = id_valid;
        s_pc = id_pc; s_p4 = id_pc_plus4; s_instr = id_instr;
        erv = !redirect_valid && memq.size() < 2 && dq.size() + memq.size() < 4;
        chk("req_valid", s_rv, erv);
        chk("req_addr", s_addr, m_pc);
        chk("id_valid", s_idv, dq.size() != 0);
        if (dq.size() != 0) begin
            chk("id_pc", s_pc, dq[0]);
            chk("id_pc_plus4", s_p4, dq[0] + 32'd4);
            chk("id_instr", s_instr, rsp_of(dq[0]));
        end
        fire = erv && imem_req_ready;
        pop  = dq.size() != 0 && id_ready;
        @(posedge clk);
        if (fire) nfire++;
        if (redirect_valid) begin
            if (rsp) void'(memq.pop_front());
            epoch++;
            dq.delete();
            m_pc = redirect_pc;
        end else begin
            if (pop) void'(dq.pop_front());
            if (rsp) begin
                e = memq.pop_front();
                if (e.ep == epoch) dq.push_back(e.addr);
            end
            if (fire) begin
                memq.push_back('{m_pc, epoch, cyc + lat});
                m_pc += 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 0; redirect_valid = 0; imem_req_ready = 0; id_ready = 0;
        stray = 0; imem_rsp_valid = 0; mem_en = 1; lat = 1;
        memq.delete(); dq.delete(); m_pc = 0; epoch++;
        #2;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_req_addr", imem_req_addr, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_pc_plus4", id_pc_plus4, 4);
        chk("rst_id_instr", id_instr, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
    endtask

    task automatic wait_head(input string nm, input logic [31:0] exp_pc);
        for (int n = 0; n < 40; n++) begin
            tick();
            if (s_idv) break;
        end
        chk({nm, "_valid"}, s_idv, 1);
        chk(nm, s_pc, exp_pc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1, 1, 1, 32'h00, 0, 32'h00};
        tbl[1]  = '{1, 1, 1, 32'h04, 0, 32'h00};
        tbl[2]  = '{1, 1, 1, 32'h08, 1, 32'h00};
        tbl[3]  = '{1, 1, 1, 32'h0C, 1, 32'h04};
        tbl[4]  = '{1, 1, 1, 32'h10, 1, 32'h08};
        tbl[5]  = '{1, 0, 1, 32'h14, 1, 32'h0C};
        tbl[6]  = '{1, 0, 0, 32'h18, 0, 32'h00};
        tbl[7]  = '{1, 1, 0, 32'h18, 0, 32'h00};
        tbl[8]  = '{1, 1, 1, 32'h18, 1, 32'h10};
        tbl[9]  = '{1, 1, 1, 32'h1C, 1, 32'h14};
        tbl[10] = '{1, 1, 1, 32'h20, 1, 32'h18};
        @(negedge clk);

        do_reset();
        imem_req_ready = 1;
        for (int i = 0; i < 11; i++) begin
            id_ready = tbl[i].idr;
            mem_en = tbl[i].men;
            tick();
            chk("tbl_req_valid", s_rv, tbl[i].rv);
            chk("tbl_req_addr", s_addr, tbl[i].addr);
            chk("tbl_id_valid", s_idv, tbl[i].idv);
            if (tbl[i].idv) chk("tbl_id_pc", s_pc, tbl[i].pc);
        end

        do_reset();
        imem_req_ready = 1;
        repeat (8) tick();
        chk("full_req_valid", s_rv, 0);
        chk("full_id_valid", s_idv, 1);
        chk("full_head", s_pc, 0);
        nfire = 0;
        id_ready = 1;
        tick();
        id_ready = 0;
        repeat (4) tick();
        chk("one_refill", nfire, 1);
        id_ready = 1;
        wait_head("drain_a", 32'h4);
        wait_head("drain_b", 32'h8);

        do_reset();
        imem_req_ready = 1; id_ready = 1; mem_en = 0;
        redirect_valid = 1; redirect_pc = 32'h8;
        tick();
        redirect_valid = 0;
        tick();
        tick();
        redirect_valid = 1; redirect_pc = 32'h100;
        tick();
        chk("rd_no_req", s_rv, 0);
        redirect_valid = 0; mem_en = 1;
        wait_head("rd_first", 32'h100);
        wait_head("rd_second", 32'h104);

        do_reset();
        imem_req_ready = 1; id_ready = 0;
        mem_en = 0; tick();
        mem_en = 1; tick();
        mem_en = 0; tick();
        chk("rd3_pre_valid", s_idv, 1);
        mem_en = 1; redirect_valid = 1; redirect_pc = 32'h200; id_ready = 1;
        tick();
        chk("rd3_no_req", s_rv, 0);
        redirect_valid = 0;
        tick();
        chk("rd3_flushed", s_idv, 0);
        chk("rd3_req", s_rv, 1);
        chk("rd3_addr", s_addr, 32'h200);
        wait_head("rd3_first", 32'h200);

        do_reset();
        imem_req_ready = 1; id_ready = 1;
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 0;
        tick();
        chk("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr_zero", s_addr, 32'h0);
        wait_head("wrap_head", 32'hFFFF_FFFC);
        chk("wrap_plus4", s_p4, 32'h0);

        do_reset();
        imem_req_ready = 1; id_ready = 1; mem_en = 0;
        tick();
        tick();
        do_reset();
        stray = 1;
        tick();
        tick();
        stray = 0;
        tick();
        chk("stray_ignored", s_idv, 0);
        chk("stray_req_valid", s_rv, 1);
        chk("stray_addr", s_addr, 32'h0);
        imem_req_ready = 1; mem_en = 1;
        wait_head("restart", 32'h0);

        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset();
            redirect_valid = $urandom_range(15) == 0;
            redirect_pc = ($urandom_range(1) == 1) ? ($urandom() & 32'h0000_FFFC)
                                                   : (32'hFFFF_FFF0 | ($urandom_range(3) << 2));
            imem_req_ready = $urandom_range(3) != 0;
            id_ready = $urandom_range(2) != 0;
            lat = $urandom_range(1, 4);
            mem_en = $urandom_range(7) != 0;
            tick();
        end

        redirect_valid = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
